divider: RTL and testbench

DIVIDER -- requirements
Module: divider

---
 rtl/divider_if.sv | 10 +
 rtl/divider.sv | 69 ++++++
 tb/tb_divider.sv | 129 ++++++++++++
 3 files changed

// File: rtl/divider_if.sv
// divider_if: CDF sample input and equalized grey-level result bundle.
interface divider_if;
  logic enable;
  logic div_en;
  logic [7:0] cdf_in;
  logic [7:0] g_out;
  logic ready_g_out;
  modport master(output enable, div_en, cdf_in, input g_out, ready_g_out);
  modport slave(input enable, div_en, cdf_in, output g_out, ready_g_out);
endinterface

// File: rtl/divider.sv
// divider: histogram-equalization scaler, g = (cdf - cdf_min) * 255 / (N_TOTAL - cdf_min), restoring division.
module divider #(
  parameter int N_TOTAL = 64
) (
  input logic clk,
  input logic reset,
  divider_if.slave bus
);
  typedef enum logic [1:0] {IDLE, LOAD, DIV} state_t;
  localparam logic [8:0] NT = 9'(N_TOTAL);
  state_t state, state_nx;
  logic [7:0] cdf_min, q, g_r, diff, den;
  logic [15:0] rem, dsh, num, trial;
  logic [2:0] cnt;
  logic rdy_r, den_bad, fit;
  assign bus.g_out = g_r;
  assign bus.ready_g_out = rdy_r;
  always_comb begin
    den_bad = {1'b0, cdf_min} >= NT;
    den = 8'(NT - {1'b0, cdf_min});
    diff = bus.cdf_in > cdf_min ? bus.cdf_in - cdf_min : 8'd0;
    num = {diff, 8'd0} - {8'd0, diff};
    fit = rem >= dsh;
    trial = rem - dsh;
    state_nx = !bus.enable ? state :
               bus.div_en ? LOAD :
               state == LOAD ? (den_bad ? LOAD : DIV) :
               (state == DIV && cnt == 3'd7) ? LOAD : state;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_nx;
  // The divisor is pre-shifted by 7 and walked right, so each DIV cycle yields one quotient bit MSB first.
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      cdf_min <= '0;
      rem <= '0;
      dsh <= '0;
      q <= '0;
      cnt <= '0;
      g_r <= '0;
      rdy_r <= 1'b0;
    end else if (!bus.enable) begin
      rdy_r <= 1'b0;
    end else begin
      rdy_r <= 1'b0;
      if (bus.div_en) begin
        cdf_min <= bus.cdf_in;
      end else if (state == LOAD) begin
        rem <= num;
        dsh <= {1'b0, den, 7'd0};
        q <= '0;
        cnt <= '0;
        if (den_bad) begin
          g_r <= 8'd255;
          rdy_r <= 1'b1;
        end
      end else if (state == DIV) begin
        if (fit) rem <= trial;
        dsh <= dsh >> 1;
        q <= {q[6:0], fit};
        cnt <= cnt + 3'd1;
        if (cnt == 3'd7) begin
          g_r <= {q[6:0], fit};
          rdy_r <= 1'b1;
        end
      end
    end
endmodule

// File: tb/tb_divider.sv
// tb_divider: directed and randomized checks of divider against an arithmetic reference.
module tb_divider;
  localparam int N = 64;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int total = 0;
  int bad = 0;
  int cmin = 0;
  int last_g = 0;
  divider_if bus();
  divider #(.N_TOTAL(N)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int model(input int m, input int v);
    if (m >= N) return 255;
    if (v <= m) return 0;
    return (v - m) * 255 / (N - m);
  endfunction

  task automatic arm(input int m);
    bus.div_en = 1'b1;
    bus.cdf_in = 8'(m);
    tick;
    bus.div_en = 1'b0;
    cmin = m;
    chk("arm_rdy", 32'(bus.ready_g_out), 0);
    chk("arm_hold", 32'(bus.g_out), last_g);
  endtask

  task automatic result(input int v, input int frz_at, input int frz_len);
    int e;
    e = model(cmin, v);
    bus.cdf_in = 8'(v);
    tick;
    bus.cdf_in = 8'($urandom);
    chk("load_rdy", 32'(bus.ready_g_out), 0);
    for (int i = 0; i < 8; i++) begin
      if (i == frz_at && frz_len > 0) begin
        bus.enable = 1'b0;
        repeat (frz_len) begin
          tick;
          chk("frz_rdy", 32'(bus.ready_g_out), 0);
          chk("frz_hold", 32'(bus.g_out), last_g);
        end
        bus.enable = 1'b1;
      end
      tick;
      if (i < 7) begin
        chk("div_rdy", 32'(bus.ready_g_out), 0);
        chk("div_hold", 32'(bus.g_out), last_g);
      end
    end
    chk("res_rdy", 32'(bus.ready_g_out), 1);
    chk("res_g", 32'(bus.g_out), e);
    last_g = e;
  endtask

  initial begin
    bus.enable = 1'b1;
    bus.div_en = 1'b0;
    bus.cdf_in = 8'd0;
    tick;
    chk("rst_g", 32'(bus.g_out), 0);
    chk("rst_rdy", 32'(bus.ready_g_out), 0);
    reset = 1'b1;
    repeat (5) begin
      tick;
      chk("idle_rdy", 32'(bus.ready_g_out), 0);
    end
    arm(1);
    result(1, 0, 0);
    result(4, 0, 0);
    result(60, 0, 0);
    result(64, 0, 0);
    arm(64);
    tick;
    chk("den0_rdy", 32'(bus.ready_g_out), 1);
    chk("den0_g", 32'(bus.g_out), 255);
    repeat (3) begin
      tick;
      chk("den0_rdy_rep", 32'(bus.ready_g_out), 1);
      chk("den0_g_rep", 32'(bus.g_out), 255);
    end
    last_g = 255;
    arm(1);
    result(0, 0, 0);
    result(50, 2, 5);
    arm(10);
    bus.cdf_in = 8'd40;
    repeat (3) tick;
    reset = 1'b0;
    #1;
    chk("async_rst_g", 32'(bus.g_out), 0);
    chk("async_rst_rdy", 32'(bus.ready_g_out), 0);
    last_g = 0;
    tick;
    reset = 1'b1;
    repeat (12) begin
      tick;
      chk("post_rst_rdy", 32'(bus.ready_g_out), 0);
      chk("post_rst_g", 32'(bus.g_out), 0);
    end
    arm(5);
    bus.cdf_in = 8'd50;
    repeat (3) tick;
    arm(20);
    result(30, 0, 0);
    for (int r = 0; r < 8; r++) begin
      arm(int'($urandom_range(0, N - 1)));
      repeat (3) result(int'($urandom_range(0, N)), int'($urandom_range(0, 7)),
                        int'($urandom_range(0, 1)) * int'($urandom_range(1, 3)));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
